// File: rtl/addr_conflict_gate_pkg.sv
// Shared types for the address-conflict admission gate: FSM state encoding and
// the saturating statistics counter type with its increment helper.
package addr_conflict_gate_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } gate_state_e;

    typedef logic [31:0] stats_cnt_t;

    localparam stats_cnt_t STATS_CNT_MAX = '1;

    // Counters hold at all-ones instead of wrapping back to zero.
    function automatic stats_cnt_t sat_inc(input stats_cnt_t v);
        return (v == STATS_CNT_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/addr_conflict_gate_track_fifo.sv
// In-order tracking FIFO for requests in flight. Push and pop may coincide;
// the parent guarantees no push when full and no pop when empty.
module addr_track_fifo
    import addr_conflict_gate_pkg::*;
#(
    parameter int unsigned DataWidth = 11,
    parameter int unsigned Depth     = 8,
    parameter int unsigned CntWidth  = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] push_data_i,
    input  logic                 pop_i,
    output logic [DataWidth-1:0] head_o,
    output logic [CntWidth-1:0]  count_o
);

    localparam int unsigned PtrWidth = $clog2(Depth);
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] mem_d [Depth];
    logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]  count_q, count_d;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrWidth'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CntWidth'(1);
            2'b01:   count_d = count_q - CntWidth'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/addr_conflict_gate.sv
// Admission gate in front of a counting Bloom filter: stalls possibly-conflicting
// requests, tracks them until in-order completion. Optional stats: ADDR_CONFLICT_GATE_STATS_EN.
module addr_conflict_gate
    import addr_conflict_gate_pkg::*;
#(
    parameter int unsigned DataWidth      = 11,
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [DataWidth-1:0] req_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] out_data_o,
    input  logic                 cpl_valid_i,
    output logic                 cpl_ready_o,
    output logic [DataWidth-1:0] look_data_o,
    input  logic                 look_hit_i,
    output logic [DataWidth-1:0] incr_data_o,
    output logic                 incr_valid_o,
    output logic [DataWidth-1:0] decr_data_o,
    output logic                 decr_valid_o,
    input  logic                 filter_full_i,
    output logic                 filter_clear_o,
    input  logic                 flush_i,
    output logic                 busy_o,
    output logic [CntWidth-1:0]  outstanding_o,
    output logic [31:0]          stall_cnt_o,
    output logic [31:0]          accept_cnt_o
);

    gate_state_e          state_q, state_d;
    logic                 out_valid_q, out_valid_d;
    logic [DataWidth-1:0] out_data_q, out_data_d;
    logic [DataWidth-1:0] fifo_head;
    logic [CntWidth-1:0]  outstanding;
    logic                 accept;
    logic                 cpl_fire;
    logic                 has_room;

    addr_track_fifo #(
        .DataWidth (DataWidth),
        .Depth     (MaxOutstanding),
        .CntWidth  (CntWidth)
    ) u_track_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (accept),
        .push_data_i (req_data_i),
        .pop_i       (cpl_fire),
        .head_o      (fifo_head),
        .count_o     (outstanding)
    );

    // Room is judged on the registered count only, so a completion in the
    // same cycle never frees a slot for an accept when the FIFO is full.
    assign has_room    = (outstanding < CntWidth'(MaxOutstanding));
    assign req_ready_o = !rst_i && (state_q == RUN) && !look_hit_i && !filter_full_i
                         && has_room && (!out_valid_q || out_ready_i);
    assign accept      = req_valid_i && req_ready_o;

    assign cpl_ready_o = !rst_i && (outstanding != '0);
    assign cpl_fire    = cpl_valid_i && cpl_ready_o;

    assign look_data_o  = req_data_i;
    assign incr_valid_o = accept;
    assign incr_data_o  = req_data_i;
    assign decr_valid_o = cpl_fire;
    assign decr_data_o  = fifo_head;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (flush_i) state_d = DRAIN;
            DRAIN:   if (outstanding == '0) state_d = CLEAR;
            CLEAR:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = req_data_i;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid_o    = out_valid_q;
    assign out_data_o     = out_data_q;
    assign busy_o         = (state_q != RUN);
    assign filter_clear_o = !rst_i && (state_q == CLEAR);
    assign outstanding_o  = outstanding;

`ifdef ADDR_CONFLICT_GATE_STATS_EN
    stats_cnt_t stall_cnt_q, stall_cnt_d;
    stats_cnt_t accept_cnt_q, accept_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        accept_cnt_d = accept_cnt_q;
        if (req_valid_i && (state_q == RUN) && look_hit_i) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
        if (accept) begin
            accept_cnt_d = sat_inc(accept_cnt_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q  <= '0;
            accept_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            accept_cnt_q <= accept_cnt_d;
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign accept_cnt_o = accept_cnt_q;
`else
    assign stall_cnt_o  = '0;
    assign accept_cnt_o = '0;
`endif

`ifndef SYNTHESIS
    // A completion with nothing tracked is dropped by the gating above, but it
    // means the downstream ordering contract was broken.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(cpl_valid_i && (outstanding == '0)))
                else $error("addr_conflict_gate: completion with no request outstanding");
        end
    end
`endif

endmodule

// File: tb/tb_addr_conflict_gate.sv
// Directed bench for addr_conflict_gate with a behavioural counting-filter model
// and a scoreboard monitor for downstream data and filter decrements.
module tb_addr_conflict_gate;

    localparam int DW   = 11;
    localparam int MAXO = 8;
    localparam int CW   = $clog2(MAXO + 1);
`ifdef ADDR_CONFLICT_GATE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [DW-1:0] req_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;
    logic          cpl_valid_i;
    logic          cpl_ready_o;
    logic [DW-1:0] look_data_o;
    logic          look_hit_i;
    logic [DW-1:0] incr_data_o;
    logic          incr_valid_o;
    logic [DW-1:0] decr_data_o;
    logic          decr_valid_o;
    logic          filter_full_i;
    logic          filter_clear_o;
    logic          flush_i;
    logic          busy_o;
    logic [CW-1:0] outstanding_o;
    logic [31:0]   stall_cnt_o;
    logic [31:0]   accept_cnt_o;

    addr_conflict_gate #(
        .DataWidth      (DW),
        .MaxOutstanding (MAXO)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_data_i     (req_data_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_data_o     (out_data_o),
        .cpl_valid_i    (cpl_valid_i),
        .cpl_ready_o    (cpl_ready_o),
        .look_data_o    (look_data_o),
        .look_hit_i     (look_hit_i),
        .incr_data_o    (incr_data_o),
        .incr_valid_o   (incr_valid_o),
        .decr_data_o    (decr_data_o),
        .decr_valid_o   (decr_valid_o),
        .filter_full_i  (filter_full_i),
        .filter_clear_o (filter_clear_o),
        .flush_i        (flush_i),
        .busy_o         (busy_o),
        .outstanding_o  (outstanding_o),
        .stall_cnt_o    (stall_cnt_o),
        .accept_cnt_o   (accept_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Exact counting filter: one counter per data value.
    int unsigned fcnt [0:(1<<DW)-1];
    assign look_hit_i = (fcnt[look_data_o] != 0);

    always @(posedge clk_i) begin
        if (rst_i || filter_clear_o) begin
            for (int i = 0; i < (1 << DW); i++) fcnt[i] <= 0;
        end else begin
            if (incr_valid_o && !(decr_valid_o && decr_data_o == incr_data_o))
                fcnt[incr_data_o] <= fcnt[incr_data_o] + 1;
            if (decr_valid_o && !(incr_valid_o && decr_data_o == incr_data_o))
                fcnt[decr_data_o] <= fcnt[decr_data_o] - 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int exp_stall = 0;
    int exp_acc   = 0;
    logic [DW-1:0] exp_out[$];
    logic [DW-1:0] exp_decr[$];
    logic [DW-1:0] trk[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One clock of stimulus; rdy is the expected req_ready_o for this cycle.
    task automatic cycle(input logic rv, input logic [DW-1:0] d, input logic cv, input logic rdy);
        req_valid_i = rv;
        req_data_i  = d;
        cpl_valid_i = cv;
        #1;
        check("outstanding", 32'(outstanding_o), 32'(trk.size()));
        check("req_ready", 32'(req_ready_o), 32'(rdy));
        check("cpl_ready", 32'(cpl_ready_o), 32'(trk.size() != 0));
        check("incr_valid", 32'(incr_valid_o), 32'(rv && rdy));
        if (cv && trk.size() != 0) exp_decr.push_back(trk.pop_front());
        if (rv && rdy) begin
            check("incr_data", 32'(incr_data_o), 32'(d));
            exp_out.push_back(d);
            trk.push_back(d);
            exp_acc++;
        end
        tick();
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_stall_cnt"}, stall_cnt_o, STATS ? 32'(exp_stall) : 32'd0);
        check({tag, "_accept_cnt"}, accept_cnt_o, STATS ? 32'(exp_acc) : 32'd0);
    endtask

    task automatic check_reset_vals();
        check("rst_out_valid", 32'(out_valid_o), 0);
        check("rst_out_data", 32'(out_data_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_outstanding", 32'(outstanding_o), 0);
        check("rst_req_ready", 32'(req_ready_o), 0);
        check("rst_cpl_ready", 32'(cpl_ready_o), 0);
        check("rst_incr_valid", 32'(incr_valid_o), 0);
        check("rst_decr_valid", 32'(decr_valid_o), 0);
        check("rst_filter_clear", 32'(filter_clear_o), 0);
        check("rst_stall_cnt", stall_cnt_o, 0);
        check("rst_accept_cnt", accept_cnt_o, 0);
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT presents output.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (out_valid_o && out_ready_i) begin
                if (exp_out.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL out_unexpected: got 0x%0h, expected no transfer", out_data_o);
                end else begin
                    check("out_data", 32'(out_data_o), 32'(exp_out.pop_front()));
                end
            end
            if (decr_valid_o) begin
                if (exp_decr.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL decr_unexpected: got 0x%0h, expected no decrement", decr_data_o);
                end else begin
                    check("decr_data", 32'(decr_data_o), 32'(exp_decr.pop_front()));
                end
            end else if (exp_decr.size() != 0) begin
                n_tests++; n_fail++;
                $display("FAIL decr_missing: got no decrement, expected 0x%0h", exp_decr[0]);
                exp_decr.delete();
            end
        end
    end

    initial begin
        rst_i = 1'b1; req_valid_i = 1'b0; req_data_i = '0; out_ready_i = 1'b1;
        cpl_valid_i = 1'b0; flush_i = 1'b0; filter_full_i = 1'b0;
        tick(); tick();
        check_reset_vals();
        rst_i = 1'b0;

        // Same-data conflict: stall until the blocking completion clears the hit.
        cycle(1, 11'h123, 0, 1);
        check("out_valid_latency", 32'(out_valid_o), 1);
        check("out_data_latency", 32'(out_data_o), 32'h123);
        cycle(1, 11'h123, 0, 0); exp_stall++;
        cycle(1, 11'h123, 1, 0); exp_stall++;
        cycle(1, 11'h123, 0, 1);
        check_stats("t1");
        cycle(0, 11'h000, 1, 1);

        // Fill to capacity; a completion at full does not admit in that cycle.
        for (int i = 0; i < MAXO; i++) cycle(1, 11'(11'h200 + i), 0, 1);
        cycle(1, 11'h208, 0, 0);
        cycle(1, 11'h208, 1, 0);
        cycle(1, 11'h208, 0, 1);
        for (int i = 0; i < MAXO; i++) cycle(0, 11'h000, 1, trk.size() < MAXO);
        check_stats("t2");

        // Same-cycle accept and completion.
        cycle(1, 11'h001, 0, 1);
        cycle(1, 11'h010, 1, 1);
        cycle(0, 11'h000, 1, 1);

        // Flush with three outstanding.
        cycle(1, 11'h031, 0, 1);
        cycle(1, 11'h032, 0, 1);
        cycle(1, 11'h033, 0, 1);
        flush_i = 1'b1;
        cycle(0, 11'h000, 0, 1);
        for (int k = 0; k < 3; k++) begin
            check("drain_busy", 32'(busy_o), 1);
            check("drain_no_clear", 32'(filter_clear_o), 0);
            cycle(1, 11'h040, 1, 0);
            flush_i = 1'b0;
        end
        check("drain_empty_clear", 32'(filter_clear_o), 0);
        cycle(1, 11'h040, 0, 0);
        check("clear_pulse", 32'(filter_clear_o), 1);
        check("clear_busy", 32'(busy_o), 1);
        cycle(1, 11'h040, 0, 0);
        check("clear_done", 32'(filter_clear_o), 0);
        check("run_busy", 32'(busy_o), 0);
        cycle(1, 11'h040, 0, 1);
        cycle(0, 11'h000, 1, 1);

        // Flush with nothing outstanding: ready low for exactly two cycles.
        flush_i = 1'b1;
        cycle(0, 11'h000, 0, 1);
        flush_i = 1'b0;
        cycle(1, 11'h050, 0, 0);
        check("empty_flush_clear", 32'(filter_clear_o), 1);
        cycle(1, 11'h050, 0, 0);
        cycle(1, 11'h050, 0, 1);

        // Downstream backpressure.
        out_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", 32'(out_valid_o), 1);
            check("bp_out_data", 32'(out_data_o), 32'h050);
            cycle(1, 11'h060, 0, 0);
        end
        out_ready_i = 1'b1;
        cycle(1, 11'h060, 0, 1);

        filter_full_i = 1'b1;
        cycle(1, 11'h070, 0, 0);
        filter_full_i = 1'b0;
        check_stats("t5");

        // Reset with four outstanding and output valid.
        cycle(1, 11'h071, 0, 1);
        cycle(1, 11'h072, 0, 1);
        check("pre_rst_out_valid", 32'(out_valid_o), 1);
        rst_i = 1'b1; req_valid_i = 1'b1; req_data_i = 11'h073; cpl_valid_i = 1'b1;
        #1;
        check("rst_cycle_req_ready", 32'(req_ready_o), 0);
        check("rst_cycle_decr", 32'(decr_valid_o), 0);
        check("rst_cycle_cpl_ready", 32'(cpl_ready_o), 0);
        tick();
        check_reset_vals();
        exp_out.delete(); exp_decr.delete(); trk.delete();
        exp_stall = 0; exp_acc = 0;
        rst_i = 1'b0; req_valid_i = 1'b0; cpl_valid_i = 1'b0;
        tick();

        cycle(1, 11'h073, 0, 1);
        cycle(0, 11'h000, 1, 1);
        cycle(0, 11'h000, 0, 1);
        check_stats("post_rst");
        check("out_queue_drained", 32'(exp_out.size()), 0);
        check("decr_queue_drained", 32'(exp_decr.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
